// File: rtl/treeval.sv
// Bottom-up expectimax evaluation over a software-loaded tree. It reports the best root action and its value.
// Latency is max(N,1)+1 cycles from START to the output update. Any write strobe aborts a running evaluation.
module treeval #(
  parameter int W_ADDR   = 10,
  parameter int W_N_DATA = 11,
  parameter int W_C_DATA = 10,
  parameter int W_REWARD = 11,
  parameter int W_ACTION = 3,
  parameter int FRAC     = 7,
  parameter int W_ACC    = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_weight,
  input  logic                       mem_par,
  input  logic                       mem_rew,
  input  logic                       mem_act,
  input  logic [W_ADDR-1:0]          mem_addr,
  input  logic [W_N_DATA-1:0]        mem_data,
  input  logic                       conf_nodes,
  input  logic [W_C_DATA-1:0]        conf_data,
  output logic                       exp_change,
  output logic signed [W_REWARD-1:0] exp,
  output logic [W_ACTION-1:0]        act
);

  localparam int NODES = 1 << W_ADDR;
  localparam int NACT  = 1 << W_ACTION;
  localparam int PW    = W_REWARD + W_N_DATA + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [W_N_DATA-1:0]        weight_mem [NODES];
  logic [W_ADDR-1:0]          par_mem    [NODES];
  logic signed [W_REWARD-1:0] rew_mem    [NODES];
  logic [W_ACTION-1:0]        act_mem    [NODES];
  logic signed [W_ACC-1:0]    acc_mem    [NODES*NACT];
  logic [NODES*NACT-1:0]      pres_mem;

  logic [1:0]                 state_q, state_d;
  logic [W_ADDR-1:0]          idx_q, idx_d;
  logic [W_C_DATA-1:0]        n_q, n_d;
  logic                       dirty_q, dirty_d;
  logic signed [W_REWARD-1:0] exp_q, exp_d;
  logic [W_ACTION-1:0]        act_q, act_d;
  logic                       chg_q, chg_d;

  logic                       strobe;
  logic [NACT-1:0]            row_pres;
  logic                       node_has;
  logic signed [W_ACC-1:0]    node_max, cand;
  logic signed [W_REWARD-1:0] node_v;
  logic signed [PW-1:0]       v_ext, w_ext, prod;
  logic signed [W_ACC-1:0]    term, acc_old, acc_new;
  logic signed [W_ACC:0]      acc_sum;
  logic [W_ADDR+W_ACTION-1:0] pa_idx;
  logic                       scan_wr;
  logic                       root_has;
  logic signed [W_ACC-1:0]    root_best, root_cand;
  logic [W_ACTION-1:0]        root_act;
  logic signed [W_REWARD-1:0] new_exp;
  logic [W_ACTION-1:0]        new_act;

  function automatic logic signed [W_REWARD-1:0] sat_rew(input logic signed [W_ACC-1:0] x);
    if (x[W_ACC-1:W_REWARD-1] == {(W_ACC-W_REWARD+1){x[W_ACC-1]}})
      return x[W_REWARD-1:0];
    else if (x[W_ACC-1])
      return {1'b1, {(W_REWARD-1){1'b0}}};
    else
      return {1'b0, {(W_REWARD-1){1'b1}}};
  endfunction

  function automatic logic signed [W_ACC-1:0] sat_acc(input logic signed [W_ACC:0] s);
    if (s[W_ACC] == s[W_ACC-1])
      return s[W_ACC-1:0];
    else if (s[W_ACC])
      return {1'b1, {(W_ACC-1){1'b0}}};
    else
      return {1'b0, {(W_ACC-1){1'b1}}};
  endfunction

  assign strobe = mem_weight | mem_par | mem_rew | mem_act | conf_nodes;

  always_ff @(posedge clk) begin
    if (mem_weight) weight_mem[mem_addr] <= mem_data;
    if (mem_par)    par_mem[mem_addr]    <= mem_data[W_ADDR-1:0];
    if (mem_rew)    rew_mem[mem_addr]    <= mem_data[W_REWARD-1:0];
    if (mem_act)    act_mem[mem_addr]    <= mem_data[W_ACTION-1:0];
  end

  // Value of the node under scan; its children have higher indices and are already folded in.
  always_comb begin
    row_pres = pres_mem[{idx_q, {W_ACTION{1'b0}}} +: NACT];
    node_has = 1'b0;
    node_max = '0;
    cand     = '0;
    for (int a = 0; a < NACT; a++) begin
      if (row_pres[a]) begin
        cand = acc_mem[{idx_q, W_ACTION'(a)}];
        if (!node_has || cand > node_max) node_max = cand;
        node_has = 1'b1;
      end
    end
    node_v  = node_has ? sat_rew(node_max) : rew_mem[idx_q];
    v_ext   = PW'(node_v);
    w_ext   = PW'({1'b0, weight_mem[idx_q]});
    prod    = v_ext * w_ext;
    term    = W_ACC'(prod >>> FRAC);
    pa_idx  = {par_mem[idx_q], act_mem[idx_q]};
    acc_old = acc_mem[pa_idx];
    acc_sum = (W_ACC+1)'(acc_old) + (W_ACC+1)'(term);
    acc_new = pres_mem[pa_idx] ? sat_acc(acc_sum) : term;
    scan_wr = (state_q == ST_SCAN) && !strobe && (par_mem[idx_q] < idx_q);
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_START) begin
      pres_mem <= '0;
    end else if (scan_wr) begin
      pres_mem[pa_idx] <= 1'b1;
      acc_mem[pa_idx]  <= acc_new;
    end
  end

  // Strict greater-than keeps the lowest-coded action on ties.
  always_comb begin
    root_has  = 1'b0;
    root_best = '0;
    root_cand = '0;
    root_act  = '0;
    for (int a = 0; a < NACT; a++) begin
      if (pres_mem[a]) begin
        root_cand = acc_mem[a];
        if (!root_has || root_cand > root_best) begin
          root_best = root_cand;
          root_act  = W_ACTION'(a);
        end
        root_has = 1'b1;
      end
    end
    new_exp = root_has ? sat_rew(root_best) : '0;
    new_act = root_has ? root_act : '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    dirty_d = dirty_q;
    exp_d   = exp_q;
    act_d   = act_q;
    chg_d   = chg_q;
    case (state_q)
      ST_IDLE: begin
        if (dirty_q) begin
          state_d = ST_START;
          dirty_d = 1'b0;
        end
      end
      ST_START: begin
        idx_d   = W_ADDR'(n_q - W_C_DATA'(1));
        state_d = (n_q <= W_C_DATA'(1)) ? ST_FINISH : ST_SCAN;
      end
      ST_SCAN: begin
        if (idx_q <= W_ADDR'(1)) state_d = ST_FINISH;
        else                     idx_d   = idx_q - W_ADDR'(1);
      end
      default: begin
        chg_d   = ({new_exp, new_act} != {exp_q, act_q});
        exp_d   = new_exp;
        act_d   = new_act;
        state_d = ST_IDLE;
      end
    endcase
    if (conf_nodes) n_d = conf_data;
    if (strobe) begin
      state_d = ST_IDLE;
      dirty_d = 1'b1;
      exp_d   = exp_q;
      act_d   = act_q;
      chg_d   = chg_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      dirty_q <= 1'b1;
      exp_q   <= '0;
      act_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      dirty_q <= dirty_d;
      exp_q   <= exp_d;
      act_q   <= act_d;
      chg_q   <= chg_d;
    end
  end

  assign exp        = exp_q;
  assign act        = act_q;
  assign exp_change = chg_q;

endmodule

// File: tb/tb_treeval.sv
// Randomized and directed checks of treeval against a child-sum expectimax reference model.
module tb_treeval;
  localparam int NMAX = 1024;

  logic clk = 1'b0;
  logic rst;
  logic mem_weight, mem_par, mem_rew, mem_act, conf_nodes;
  logic [9:0]  mem_addr;
  logic [10:0] mem_data;
  logic [9:0]  conf_data;
  logic        chg_o;
  logic signed [10:0] exp_o;
  logic [2:0]  act_o;

  always #5 clk = ~clk;

  treeval dut (
    .clk        (clk),
    .rst        (rst),
    .mem_weight (mem_weight),
    .mem_par    (mem_par),
    .mem_rew    (mem_rew),
    .mem_act    (mem_act),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .conf_nodes (conf_nodes),
    .conf_data  (conf_data),
    .exp_change (chg_o),
    .exp        (exp_o),
    .act        (act_o)
  );

  int m_par [NMAX];
  int m_rew [NMAX];
  int m_act [NMAX];
  int m_w   [NMAX];
  int cur_n  = 0;
  int prev_e = 0;
  int prev_a = 0;
  int n_vec  = 0;
  int n_err  = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic chk_out(input string tag, input int e, input int a, input int c);
    chk({tag, ".exp"}, int'(exp_o), e);
    chk({tag, ".act"}, int'(act_o), a);
    chk({tag, ".chg"}, int'(chg_o), c);
  endtask

  // Caller is at a negedge; one strobe cycle, returning at the following negedge.
  task automatic wr(input int kind, input int addr, input int data);
    mem_addr  = addr[9:0];
    mem_data  = data[10:0];
    conf_data = data[9:0];
    case (kind)
      0: begin mem_weight = 1'b1; m_w[addr]   = data; end
      1: begin mem_par    = 1'b1; m_par[addr] = data; end
      2: begin mem_rew    = 1'b1; m_rew[addr] = data; end
      3: begin mem_act    = 1'b1; m_act[addr] = data; end
      default: begin conf_nodes = 1'b1; cur_n = data; end
    endcase
    @(negedge clk);
    mem_weight = 1'b0; mem_par = 1'b0; mem_rew = 1'b0; mem_act = 1'b0; conf_nodes = 1'b0;
  endtask

  task automatic wr_node(input int i, input int p, input int r, input int a, input int w);
    wr(1, i, p);
    wr(2, i, r);
    wr(3, i, a);
    wr(0, i, w);
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic int sat(input int x, input int bits);
    int lim;
    lim = 1 << (bits - 1);
    if (x > lim - 1) return lim - 1;
    if (x < -lim)    return -lim;
    return x;
  endfunction

  function automatic int floor128(input int x);
    if (x >= 0) return x / 128;
    return -((-x + 127) / 128);
  endfunction

  // Each node gathers weighted child values per action label; parent index below child is implied by p<c.
  function automatic void model(input int n, output int e, output int a);
    int val [NMAX];
    int sum [8];
    bit has [8];
    int best, ba, t, k;
    bit any;
    e = 0;
    a = 0;
    for (int p = n - 1; p >= 0; p--) begin
      for (int j = 0; j < 8; j++) begin sum[j] = 0; has[j] = 1'b0; end
      for (int c = p + 1; c < n; c++) begin
        if (m_par[c] == p) begin
          t = floor128(val[c] * m_w[c]);
          k = m_act[c];
          sum[k] = has[k] ? sat(sum[k] + t, 18) : t;
          has[k] = 1'b1;
        end
      end
      any = 1'b0; best = 0; ba = 0;
      for (int j = 0; j < 8; j++) begin
        if (has[j] && (!any || sum[j] > best)) begin
          best = sum[j];
          ba   = j;
        end
        if (has[j]) any = 1'b1;
      end
      if (p == 0) begin
        if (any) begin e = sat(best, 11); a = ba; end
      end else begin
        val[p] = any ? sat(best, 11) : m_rew[p];
      end
    end
  endfunction

  task automatic expect_eval(input string tag);
    int e, a, c, nn;
    model(cur_n, e, a);
    c  = (e != prev_e || a != prev_a) ? 1 : 0;
    nn = (cur_n > 1) ? cur_n : 1;
    wait_neg(nn + 2);
    chk_out(tag, e, a, c);
    prev_e = e;
    prev_a = a;
  endtask

  task automatic load_ref_tree();
    int rp [7] = '{0, 0, 0, 0, 1, 1, 1};
    int rr [7] = '{0, 0, -10, 0, 100, -50, 10};
    int ra [7] = '{0, 1, 1, 0, 1, 1, 0};
    int rw [7] = '{0, 64, 64, 128, 64, 64, 128};
    for (int i = 0; i < 7; i++) wr_node(i, rp[i], rr[i], ra[i], rw[i]);
    wr(4, 0, 7);
  endtask

  initial begin
    int n, p, r, a, w;
    rst = 1'b0;
    mem_weight = 1'b0; mem_par = 1'b0; mem_rew = 1'b0; mem_act = 1'b0; conf_nodes = 1'b0;
    mem_addr = '0; mem_data = '0; conf_data = '0;
    wait_neg(3);
    chk_out("reset", 0, 0, 0);
    rst = 1'b1;
    wait_neg(5);
    chk_out("n0", 0, 0, 0);

    load_ref_tree();
    wait_neg(8);
    chk("ref.early_chg", int'(chg_o), 0);
    wait_neg(1);
    chk_out("ref", 7, 1, 1);
    prev_e = 7; prev_a = 1;

    wr(2, 2, -10);
    wait_neg(9);
    chk_out("rewrite", 7, 1, 0);

    wr(2, 4, -100);
    wait_neg(9);
    chk_out("n4neg", 0, 0, 1);

    wr_node(0, 0, 0, 0, 0);
    wr_node(1, 0, -1, 2, 64);
    wr(4, 0, 2);
    wait_neg(4);
    chk_out("negfloor", -1, 2, 1);

    load_ref_tree();
    wait_neg(3);
    wr(2, 4, 100);
    wait_neg(5);
    chk_out("abort.hold", -1, 2, 1);
    wait_neg(4);
    chk_out("abort.new", 7, 1, 1);

    wr(2, 2, -10);
    wait_neg(4);
    rst = 1'b0;
    #1;
    chk_out("rst.mid", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    cur_n = 0; prev_e = 0; prev_a = 0;
    wait_neg(4);
    chk_out("rst.after", 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      n = (t == 0) ? 1 : int'($urandom_range(2, 20));
      for (int i = 0; i < n; i++) begin
        if (i == 0)                          p = 0;
        else if ($urandom_range(0, 5) == 0)  p = int'($urandom_range(i, 1023));
        else                                 p = int'($urandom_range(0, i - 1));
        r = int'($urandom_range(0, 2047)) - 1024;
        a = int'($urandom_range(0, 3));
        w = int'($urandom_range(0, 255));
        wr_node(i, p, r, a, w);
      end
      wr(4, 0, n);
      expect_eval($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
